stack_ctrl: RTL
===============

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits SHALL be provided.
REQ-002 Parameter ADDR, default 4, stack depth 2**ADDR entries SHALL be provided.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op_valid  input  1  requester presents an operation.
REQ-006 op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 DROP, 4 SELECT, 5-7 invalid.
REQ-007 op_data  input  WIDTH  operand for PUSH.
REQ-008 op_ready  output  1  controller accepts op this cycle.
REQ-009 out_valid  output  1  one-cycle strobe, out_data valid.
REQ-010 out_data  output  WIDTH  value returned by POP.
REQ-011 empty  output  1  high when stack count is 0.
REQ-012 count  output  ADDR+1  current number of stacked entries.
REQ-013 trap  output  4  0 none, 1 underflow, 2 overflow, 3 invalid opcode.

Function
REQ-014 An op SHALL be accepted only on a cycle with op_valid && op_ready; op_ready SHALL be high only in state IDLE with trap==0.
REQ-015 Storage SHALL be a single-read-port, single-write-port array with registered (1-cycle) read; reads and writes SHALL not use combinational array output.
REQ-016 FSM states: IDLE, POP_RD, POP_OUT, SEL_C, SEL_V2, SEL_V1, SEL_WR, TRAP.
REQ-017 NOP: no state change; op_ready stays high.
REQ-018 PUSH: write op_data at index count, count+1 at the accept edge; stays IDLE; back-to-back PUSH every cycle SHALL be supported.
REQ-019 POP: IDLE->POP_RD->POP_OUT->IDLE; out_valid high exactly one cycle, 2 cycles after accept edge, out_data = entry count-1; count-1 on leaving POP_OUT.
REQ-020 DROP: count-1 at accept edge; no out_valid; stays IDLE.
REQ-021 SELECT: pops c (top), val2, val1; pushes val1 if c!=0 else val2; sequence SEL_C->SEL_V2->SEL_V1->SEL_WR->IDLE; count decreases by exactly 2; op_ready high again 4 cycles after accept edge.
REQ-022 c SHALL be tested as nonzero over all WIDTH bits.
REQ-023 Underflow: POP/DROP with count==0, or SELECT with count<3, SHALL not modify storage or count; trap=1; FSM->TRAP at accept edge.
REQ-024 Overflow: PUSH with count==2**ADDR SHALL not write; trap=2; FSM->TRAP.
REQ-025 Invalid opcode 5-7 SHALL set trap=3, FSM->TRAP, no other state change.
REQ-026 TRAP SHALL be sticky until reset; op_ready=0, out_valid=0 while trapped.
REQ-027 empty SHALL equal (count==0) combinationally from count register.
REQ-028 out_data SHALL hold its last value when out_valid is low.
REQ-029 op_valid while op_ready low SHALL be ignored (requester holds op until accepted).

Reset
REQ-030 reset high at a rising edge SHALL force: FSM IDLE, count 0, trap 0, out_valid 0, out_data 0, empty 1, op_ready 1 on the following cycle.
REQ-031 reset SHALL abort any in-progress POP or SELECT without out_valid and without storage write; reset SHALL take priority over a simultaneous op.
REQ-032 Array contents need not be cleared by reset.

Verification
REQ-033 PUSH 1, PUSH 2, PUSH 0, SELECT, POP -> out_data=2, out_valid one cycle, count=0, empty=1, trap=0.
REQ-034 PUSH 1, PUSH 2, PUSH 7, SELECT, POP -> out_data=1; op_ready low exactly 4 cycles after SELECT accept.
REQ-035 POP on empty stack -> trap=1, count=0, op_ready=0 thereafter; reset -> trap=0, op_ready=1.
REQ-036 ADDR=2: 4 PUSHes then 5th PUSH -> trap=2, count=4; earlier entries intact after reset-free inspection via count.
REQ-037 PUSH 5, PUSH 6, PUSH 9 then SELECT with reset asserted 2 cycles after accept -> count=0, no out_valid, trap=0.
REQ-038 op=6 accepted -> trap=3, count unchanged, out_valid never asserted.

Source files
------------

// File: rtl/stack_ctrl.sv
// Operand-stack controller: PUSH/POP/DROP/SELECT over a 2**ADDR-entry array.
// The array has one registered read port. Any fault parks the FSM in a sticky TRAP state.
module stack_ctrl #(
    parameter int WIDTH = 64,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             empty,
    output logic [ADDR:0]    count,
    output logic [3:0]       trap
);

    localparam int CW    = ADDR + 1;
    localparam int DEPTH = 2 ** ADDR;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_POP    = 3'd2;
    localparam logic [2:0] OP_DROP   = 3'd3;
    localparam logic [2:0] OP_SELECT = 3'd4;

    localparam logic [3:0] TRAP_NONE  = 4'd0;
    localparam logic [3:0] TRAP_UNDER = 4'd1;
    localparam logic [3:0] TRAP_OVER  = 4'd2;
    localparam logic [3:0] TRAP_INVOP = 4'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP_RD  = 3'd1,
        POP_OUT = 3'd2,
        SEL_C   = 3'd3,
        SEL_V2  = 3'd4,
        SEL_V1  = 3'd5,
        SEL_WR  = 3'd6,
        TRAP    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [3:0]        trap_q, trap_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              op_ready_q, op_ready_d;
    logic [WIDTH-1:0]  val2_q, val2_d;
    logic              c_nz_q, c_nz_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rd_data_q;

    logic              accept_s;
    logic              mem_we_s;
    logic              mem_we_g_s;
    logic [ADDR-1:0]   mem_wa_s;
    logic [WIDTH-1:0]  mem_wd_s;
    logic              mem_re_s;
    logic [ADDR-1:0]   mem_ra_s;
    logic [CW-1:0]     cnt_m1_s;
    logic [CW-1:0]     cnt_m2_s;
    logic [ADDR-1:0]   idx_m1_s;
    logic [ADDR-1:0]   idx_m2_s;
    logic [ADDR-1:0]   idx_m3_s;

    assign accept_s   = op_valid & op_ready_q;
    assign cnt_m1_s   = count_q - CW'(1'b1);
    assign cnt_m2_s   = count_q - CW'(2'd2);
    assign idx_m1_s   = count_q[ADDR-1:0] - ADDR'(1'b1);
    assign idx_m2_s   = count_q[ADDR-1:0] - ADDR'(2'd2);
    assign idx_m3_s   = count_q[ADDR-1:0] - ADDR'(2'd3);
    // A reset on the same edge as a pending write must leave the array untouched.
    assign mem_we_g_s = mem_we_s & ~reset;

    // Next-state, datapath and array-port control for the whole controller.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        trap_d      = trap_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        val2_d      = val2_q;
        c_nz_d      = c_nz_q;
        mem_we_s    = 1'b0;
        mem_wa_s    = count_q[ADDR-1:0];
        mem_wd_s    = op_data;
        mem_re_s    = 1'b0;
        mem_ra_s    = idx_m1_s;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_NOP: begin
                            state_d = IDLE;
                        end
                        OP_PUSH: begin
                            if (count_q == CW'(DEPTH)) begin
                                trap_d  = TRAP_OVER;
                                state_d = TRAP;
                            end else begin
                                mem_we_s = 1'b1;
                                count_d  = count_q + CW'(1'b1);
                            end
                        end
                        OP_POP: begin
                            if (count_q == CW'(1'b0)) begin
                                trap_d  = TRAP_UNDER;
                                state_d = TRAP;
                            end else begin
                                state_d = POP_RD;
                            end
                        end
                        OP_DROP: begin
                            if (count_q == CW'(1'b0)) begin
                                trap_d  = TRAP_UNDER;
                                state_d = TRAP;
                            end else begin
                                count_d = cnt_m1_s;
                            end
                        end
                        OP_SELECT: begin
                            if (count_q < CW'(2'd3)) begin
                                trap_d  = TRAP_UNDER;
                                state_d = TRAP;
                            end else begin
                                state_d = SEL_C;
                            end
                        end
                        default: begin
                            trap_d  = TRAP_INVOP;
                            state_d = TRAP;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            POP_RD: begin
                mem_re_s = 1'b1;
                mem_ra_s = idx_m1_s;
                state_d  = POP_OUT;
            end
            POP_OUT: begin
                out_valid_d = 1'b1;
                out_data_d  = rd_data_q;
                count_d     = cnt_m1_s;
                state_d     = IDLE;
            end
            SEL_C: begin
                mem_re_s = 1'b1;
                mem_ra_s = idx_m1_s;
                state_d  = SEL_V2;
            end
            SEL_V2: begin
                // rd_data_q holds the condition word; test every bit of it.
                c_nz_d   = |rd_data_q;
                mem_re_s = 1'b1;
                mem_ra_s = idx_m2_s;
                state_d  = SEL_V1;
            end
            SEL_V1: begin
                val2_d   = rd_data_q;
                mem_re_s = 1'b1;
                mem_ra_s = idx_m3_s;
                state_d  = SEL_WR;
            end
            SEL_WR: begin
                mem_we_s = 1'b1;
                mem_wa_s = idx_m3_s;
                mem_wd_s = c_nz_q ? rd_data_q : val2_q;
                count_d  = cnt_m2_s;
                state_d  = IDLE;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        op_ready_d = (state_d == IDLE) && (trap_d == TRAP_NONE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            trap_q      <= TRAP_NONE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            op_ready_q  <= 1'b1;
            val2_q      <= '0;
            c_nz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            trap_q      <= trap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            op_ready_q  <= op_ready_d;
            val2_q      <= val2_d;
            c_nz_q      <= c_nz_d;
        end
    end

    // Storage array: one write port, one registered read port, contents not reset.
    always_ff @(posedge clk) begin
        if (mem_we_g_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
        if (mem_re_s) begin
            rd_data_q <= mem_q[mem_ra_s];
        end
    end

    assign op_ready  = op_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign trap      = trap_q;
    assign empty     = (count_q == CW'(1'b0));

endmodule
